// File: rtl/alu_pkg.sv
// Shared ALU function codes and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] FUNC_ADD   = 4'd0;
  localparam logic [3:0] FUNC_SUB   = 4'd1;
  localparam logic [3:0] FUNC_AND   = 4'd2;
  localparam logic [3:0] FUNC_OR    = 4'd3;
  localparam logic [3:0] FUNC_XOR   = 4'd4;
  localparam logic [3:0] FUNC_NOT   = 4'd5;
  localparam logic [3:0] FUNC_SLL   = 4'd6;
  localparam logic [3:0] FUNC_SRL   = 4'd7;
  localparam logic [3:0] FUNC_SRA   = 4'd8;
  localparam logic [3:0] FUNC_ID    = 4'd9;
  localparam logic [3:0] FUNC_INC   = 4'd10;
  localparam logic [3:0] FUNC_DEC   = 4'd11;
  localparam logic [3:0] FUNC_NEG   = 4'd12;
  localparam logic [3:0] FUNC_SLT   = 4'd13;
  localparam logic [3:0] FUNC_PASSB = 4'd14;
  localparam logic [3:0] FUNC_ZERO  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid bit at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    idx_o
);

  logic        found;
  int unsigned j;

  // Scan from the pointer upwards; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid_i[j[IdxW-1:0]]) begin
        found                = 1'b1;
        grant_o[j[IdxW-1:0]] = 1'b1;
        idx_o                = j[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One operation per three cycles: grant (IDLE), execute (EXEC), respond (RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]            req_func,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  output logic [3:0]                      alu_func,
  input  logic [DATA_WIDTH-1:0]           alu_c,
  input  logic                            alu_ovf,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_ovf,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            op_count
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]            func_q, func_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_ovf_q, rsp_ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IdxW-1:0]       pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_picker (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx)
  );

  // ALU inputs come straight from the operand registers so they never glitch.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_func  = func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state, datapath capture and the combinational grant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    func_d      = func_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = pick_gnt;
          a_d       = req_a[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
          b_d       = req_b[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
          func_d    = req_func[32'(pick_idx) * 4 +: 4];
          gnt_d     = pick_idx;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_c;
        rsp_ovf_d   = alu_ovf;
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        ptr_d       = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + IdxW'(1);
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      func_q      <= func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences and
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*4-1:0] req_func = '0;

  logic [N-1:0] req_ready, rsp_valid;
  logic [W-1:0] alu_a, alu_b, alu_c, rsp_data;
  logic [3:0]   alu_func;
  logic         alu_ovf, rsp_ovf, busy;
  logic [15:0]  op_count;

  logic [N-1:0] rdy4, rv4;
  logic [W-1:0] a4, b4, c4, rd4;
  logic [3:0]   f4;
  logic         ovf4, ro4, busy4;
  logic [3:0]   op_count4;

  always #5 clk = ~clk;

  // Reference ALU: acts as the shared ALU and as the model's result source.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] f);
    logic [W-1:0] c;
    logic         v;
    v = 1'b0;
    case (f)
      FUNC_ADD:   begin c = a + b; v = (a[W-1] == b[W-1]) && (c[W-1] != a[W-1]); end
      FUNC_SUB:   begin c = a - b; v = (a[W-1] != b[W-1]) && (c[W-1] != a[W-1]); end
      FUNC_AND:   c = a & b;
      FUNC_OR:    c = a | b;
      FUNC_XOR:   c = a ^ b;
      FUNC_NOT:   c = ~a;
      FUNC_SLL:   c = a << b[3:0];
      FUNC_SRL:   c = a >> b[3:0];
      FUNC_SRA:   c = $signed(a) >>> b[3:0];
      FUNC_ID:    c = a;
      FUNC_INC:   begin c = a + 1'b1; v = (a == 16'h7FFF); end
      FUNC_DEC:   begin c = a - 1'b1; v = (a == 16'h8000); end
      FUNC_NEG:   begin c = -a; v = (a == 16'h8000); end
      FUNC_SLT:   c = {15'd0, $signed(a) < $signed(b)};
      FUNC_PASSB: c = b;
      default:    c = '0;
    endcase
    return {v, c};
  endfunction

  assign {alu_ovf, alu_c} = alu_ref(alu_a, alu_b, alu_func);
  assign {ovf4, c4}       = alu_ref(a4, b4, f4);

  alu_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy),
    .op_count(op_count)
  );

  // Narrow-counter copy fed the same requests, used for the wrap check.
  alu_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy4),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .alu_a(a4), .alu_b(b4), .alu_func(f4), .alu_c(c4), .alu_ovf(ovf4),
    .rsp_valid(rv4), .rsp_data(rd4), .rsp_ovf(ro4), .busy(busy4),
    .op_count(op_count4)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  int           cyc = 0;
  int           m_ptr, m_idle_at, alu_cyc, rsp_cyc, e_cnt;
  logic [W-1:0] e_a, e_b, e_data, s_a, s_b, s_data;
  logic [3:0]   e_f, s_f;
  logic         e_ovf, s_ovf;
  logic [N-1:0] s_oh, e_rv, e_ready, seen_ready = '0;
  logic         e_busy, found;

  task automatic model_reset();
    m_ptr = 0; m_idle_at = 0; alu_cyc = -1; rsp_cyc = -1; e_cnt = 0;
    e_a = '0; e_b = '0; e_f = '0; e_data = '0; e_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        model_reset();
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", {rsp_ovf, rsp_data}, 0);
        chk("rst_alu", {alu_func, alu_b, alu_a}, 0);
        chk("rst_count", {op_count4, op_count}, 0);
        seen_ready = '0;
      end else begin
        if (cyc == alu_cyc) begin e_a = s_a; e_b = s_b; e_f = s_f; end
        if (cyc == rsp_cyc) begin e_data = s_data; e_ovf = s_ovf; e_cnt++; end
        e_rv    = (cyc == rsp_cyc) ? s_oh : '0;
        e_busy  = (cyc < m_idle_at);
        e_ready = '0;
        found   = 1'b0;
        if (!e_busy) begin
          for (int k = 0; k < N; k++) begin
            int g;
            g = (m_ptr + k) % N;
            if (!found && req_valid[g]) begin
              found      = 1'b1;
              e_ready[g] = 1'b1;
              s_a        = req_a[g*W +: W];
              s_b        = req_b[g*W +: W];
              s_f        = req_func[g*4 +: 4];
              {s_ovf, s_data} = alu_ref(s_a, s_b, s_f);
              s_oh       = N'(1) << g;
              alu_cyc    = cyc + 1;
              rsp_cyc    = cyc + 2;
              m_ptr      = (g + 1) % N;
              m_idle_at  = cyc + 3;
            end
          end
        end
        chk("ready", req_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_ovf", rsp_ovf, e_ovf);
        chk("alu_in", {alu_func, alu_b, alu_a}, {e_f, e_b, e_a});
        chk("op_count", op_count, e_cnt % 65536);
        chk("op_count4", op_count4, e_cnt % 16);
        seen_ready = req_ready;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f);
    req_a[r*W +: W]  = a;
    req_b[r*W +: W]  = b;
    req_func[r*4 +: 4] = f;
  endtask

  // Returns at the negedge of the cycle in which any grant is seen.
  task automatic wait_grant(input string name, output logic [N-1:0] g);
    g = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        return;
      end
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    int         r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0] f;
    logic [W-1:0] c;
    logic       ovf;
  } vec_t;

  vec_t         tbl[16];
  logic [N-1:0] g;
  realtime      t_prev, t_now;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 16'h7FFF, 16'h0001, FUNC_ADD,   16'h8000, 1'b1};
    tbl[1]  = '{1, 16'h0005, 16'h0003, FUNC_SUB,   16'h0002, 1'b0};
    tbl[2]  = '{2, 16'h8000, 16'h0001, FUNC_SUB,   16'h7FFF, 1'b1};
    tbl[3]  = '{3, 16'hF0F0, 16'h0FF0, FUNC_AND,   16'h00F0, 1'b0};
    tbl[4]  = '{0, 16'h00AA, 16'h0F00, FUNC_OR,    16'h0FAA, 1'b0};
    tbl[5]  = '{1, 16'hFFFF, 16'h00FF, FUNC_XOR,   16'hFF00, 1'b0};
    tbl[6]  = '{2, 16'h1234, 16'h0000, FUNC_NOT,   16'hEDCB, 1'b0};
    tbl[7]  = '{3, 16'h0001, 16'h0004, FUNC_SLL,   16'h0010, 1'b0};
    tbl[8]  = '{0, 16'h8000, 16'h0003, FUNC_SRA,   16'hF000, 1'b0};
    tbl[9]  = '{1, 16'h8000, 16'h000F, FUNC_SRL,   16'h0001, 1'b0};
    tbl[10] = '{2, 16'h7FFF, 16'h0000, FUNC_INC,   16'h8000, 1'b1};
    tbl[11] = '{3, 16'hFFFE, 16'h0001, FUNC_SLT,   16'h0001, 1'b0};
    tbl[12] = '{0, 16'h1234, 16'h5678, FUNC_PASSB, 16'h5678, 1'b0};
    tbl[13] = '{1, 16'hABCD, 16'h1111, FUNC_ZERO,  16'h0000, 1'b0};
    tbl[14] = '{2, 16'h8000, 16'h0000, FUNC_NEG,   16'h8000, 1'b1};
    tbl[15] = '{3, 16'h0000, 16'h0000, FUNC_DEC,   16'hFFFF, 1'b0};

    do_reset();

    // Directed table: single ops, handshake at N, response at N+2.
    foreach (tbl[i]) begin
      set_req(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].f);
      req_valid[tbl[i].r] = 1'b1;
      wait_grant("tbl_grant", g);
      chk("tbl_grant", g, N'(1) << tbl[i].r);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("tbl_alu_a", alu_a, tbl[i].a);
      @(negedge clk);
      chk("tbl_rsp_valid", rsp_valid, N'(1) << tbl[i].r);
      chk("tbl_rsp_data", rsp_data, tbl[i].c);
      chk("tbl_rsp_ovf", rsp_ovf, tbl[i].ovf);
      tick();
    end

    // Round-robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, W'(i), 16'h0000, FUNC_ID);
    req_valid = '1;
    t_prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr_grant", g);
      t_now = $realtime;
      chk("rr_grant", g, N'(1) << (n % N));
      if (n > 0) chk("rr_spacing", 32'(int'(t_now - t_prev)), 30);
      t_prev = t_now;
      tick();
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp_data", rsp_data, n % N);
    end
    tick();
    req_valid = '0;

    // Pointer wrap: after granting 3, requester 0 beats requester 2.
    do_reset();
    set_req(3, 16'h0003, 16'h0000, FUNC_ID);
    req_valid = 4'b1000;
    wait_grant("wrap_g3", g);
    chk("wrap_g3", g, 4'b1000);
    tick();
    set_req(0, 16'h0010, 16'h0000, FUNC_ID);
    set_req(2, 16'h0020, 16'h0000, FUNC_ID);
    req_valid = 4'b0101;
    wait_grant("wrap_first", g);
    chk("wrap_first", g, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    wait_grant("wrap_second", g);
    chk("wrap_second", g, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Operand stability: changing req_a after the handshake has no effect.
    set_req(1, 16'd5, 16'd3, FUNC_SUB);
    req_valid[1] = 1'b1;
    wait_grant("stab_grant", g);
    tick();
    req_a[1*W +: W] = 16'd9;
    req_valid = '0;
    @(negedge clk);
    chk("stab_alu", {alu_func, alu_b, alu_a}, {FUNC_SUB, 16'd3, 16'd5});
    @(negedge clk);
    chk("stab_rsp", {rsp_valid, rsp_ovf, rsp_data}, {4'b0010, 1'b0, 16'd2});
    tick();

    // Reset during EXEC: op discarded, pointer back to 0.
    do_reset();
    set_req(0, 16'h0011, 16'h0000, FUNC_ID);
    req_valid = 4'b0001;
    wait_grant("rm_first", g);
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    tick();
    set_req(2, 16'h0022, 16'h0000, FUNC_ID);
    req_valid = 4'b0100;
    wait_grant("rm_inflight", g);
    tick();
    req_valid = '0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rm_busy", busy, 0);
    chk("rm_count", op_count, 0);
    chk("rm_alu", {alu_func, alu_b, alu_a}, 0);
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("rm_no_rsp", rsp_valid, 0);
    end
    tick();
    set_req(0, 16'h0033, 16'h0000, FUNC_ID);
    set_req(3, 16'h0044, 16'h0000, FUNC_ID);
    req_valid = 4'b1001;
    wait_grant("rm_ptr0", g);
    chk("rm_ptr0", g, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rm_rsp_data", rsp_data, 16'h0033);
    tick();

    // Counter wrap on the 4-bit instance: 17 ops leave it at 1.
    do_reset();
    for (int n = 0; n < 17; n++) begin
      set_req(n % N, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      req_valid[n % N] = 1'b1;
      wait_grant("cw_grant", g);
      tick();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("cw_count4", op_count4, 1);
    chk("cw_count16", op_count, 17);
    tick();

    // Randomized traffic obeying the handshake rules.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (c == 700) begin
        req_valid = '0;
        reset_n   = 1'b0;
        tick();
        reset_n   = 1'b1;
      end
      for (int r = 0; r < N; r++) begin
        if (req_valid[r] && seen_ready[r]) begin
          if ($urandom_range(0, 1) == 0) req_valid[r] = 1'b0;
          set_req(r, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end else if (req_valid[r]) begin
          if ($urandom_range(0, 9) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(r, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
          req_valid[r] = 1'b1;
        end
      end
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
